compmult_pipe: RTL
==================

Name: compmult_pipe

Overview:
- Parametrised, fully pipelined signed complex multiplier computing c = a*b, using the 3-multiplier form.
- Adds valid/ready handshaking with backpressure, a sideband tag, output scaling with round-half-up, and saturation with an overflow flag.
- Sits in the datapath wherever a streaming complex multiply is needed (mixers, FFT twiddles, channel correction).

Parameters:
- N, 8, input component width (signed, two's complement).
- OUT_W, 2*N+1, output component width; full precision when SHIFT=0.
- SHIFT, 0, arithmetic right shift applied to full-precision result before saturation; range 0..2*N.
- TAG_W, 4, width of the sideband tag carried alongside each sample; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input this cycle.
- a_r  in  N  operand a real part.
- a_i  in  N  operand a imag part.
- b_r  in  N  operand b real part.
- b_i  in  N  operand b imag part.
- conj  in  1  compute a*conj(b); used only with CMULT_CONJ_EN.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- c_r  out  OUT_W  result real part.
- c_i  out  OUT_W  result imag part.
- out_ovf  out  1  saturation occurred on c_r or c_i for this sample.
- out_tag  out  TAG_W  tag of this sample.

Behaviour:
- Reset: one clock, asynchronous active-high. Every pipeline register, all valid bits, c_r, c_i, out_ovf, out_tag and out_valid clear to 0 immediately.
- Reset mid-stream discards all in-flight samples. No output appears until new inputs are accepted.
- Handshake: a transfer occurs when valid and ready are both high on the same rising edge.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. The whole pipe advances only when en is high.
- Bubbles are not collapsed. A stalled output holds c_r, c_i, out_ovf and out_tag stable until accepted.
- Latency: 4 enabled cycles from input acceptance to out_valid. With out_ready tied high, throughput is 1 sample per clock.
- Stage 0:
  - Register a_r and a_i.
  - Register br and bi, each N+1 bits; bi = conj ? -b_i : b_i, so that -(-2^(N-1)) is exact.
  - Register sa = a_r + a_i and sb = br + bi, each N+2 bits.
- Stage 1 (products, each 2N+3 bits, sign-extended):
  - k1 = br*sa
  - k2 = a_r*(bi - br)
  - k3 = a_i*sb
- Stage 2: re = k1 - k3, im = k1 + k2, at full precision. This equals ar*br - ai*bi and ar*bi + ai*br.
- Stage 3 (output register):
  - Rounding: x_s = (x + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT. This is round-half-toward-+inf.
  - Saturation: if x_s is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], clamp to the nearest limit.
  - out_ovf = saturation on either component.
- Tags and valid bits travel in lockstep with the data.
- in_valid=0 with en=1 inserts a bubble (valid bit 0). Data registers may update, but out_valid stays 0 for that slot.
- Simultaneous output accept and input accept in one cycle is legal and required for full throughput.

Optional Feature:
- CMULT_CONJ_EN defined: conj is sampled with each accepted input and selects a*conj(b) for that sample only.
- CMULT_CONJ_EN undefined: conj is ignored and treated as 0. The port stays present so the interface is identical.

Test Plan:
1. N=8, OUT_W=17, SHIFT=0, out_ready=1: a=3+4j, b=5-2j, tag=5 -> exactly 4 cycles later out_valid=1, c=23+14j, out_ovf=0, out_tag=5.
2. Extremes: a=b=-128-128j -> c=0+32768j, no overflow. Repeat with OUT_W=16 -> c=0+32767j, out_ovf=1.
3. SHIFT=2, OUT_W=15: a=3+4j, b=5-2j -> c=6+4j. Then a=-3+0j, b=2+0j (full value -6) -> c_r=-1.
4. CMULT_CONJ_EN defined: a=3+4j, b=5-2j, conj=1 -> c=7+26j. Back-to-back sample with conj=0 -> 23+14j. Undefined: conj=1 still gives 23+14j.
5. Backpressure: stream 8 tagged samples with out_ready toggling 1,0,0,1,... -> in_ready follows en, outputs hold while stalled, no loss or duplication, tags arrive in order with correct products.
6. Reset asserted asynchronously mid-clock with 3 samples in flight -> outputs and out_valid go to 0 immediately. After release, only the newly accepted samples emerge, with 4-cycle latency.

Source files
------------

// File: rtl/compmult_pipe.sv
// compmult_pipe: fully pipelined signed complex multiplier c = a*b (or
// a*conj(b)), built on the 3-multiplier form. The result is rounded
// half-up, arithmetically right-shifted by SHIFT and saturated to OUT_W
// bits. A sideband tag travels with each sample.
//
// Optional feature: define CMULT_CONJ_EN to honour the per-sample conj
// input. When the macro is undefined, conj is ignored and treated as 0.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = pipeline enable)
//   a_r,a_i,b_r,b_i     signed N-bit operands
//   conj                select a*conj(b) for this sample (CMULT_CONJ_EN)
//   in_tag              sideband tag accepted with the sample
//   out_valid/out_ready output handshake
//   c_r,c_i             signed OUT_W-bit result
//   out_ovf             saturation hit on c_r or c_i
//   out_tag             tag of the presented sample
//
// Latency is 4 enabled cycles. The whole pipe stalls together while an
// output is held. Bubbles are kept and are not collapsed.
module compmult_pipe #(
    parameter int N     = 8,
    parameter int OUT_W = 2*N+1,
    parameter int SHIFT = 0,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     a_r,
    input  logic signed [N-1:0]     a_i,
    input  logic signed [N-1:0]     b_r,
    input  logic signed [N-1:0]     b_i,
    input  logic                    conj,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] c_r,
    output logic signed [OUT_W-1:0] c_i,
    output logic                    out_ovf,
    output logic [TAG_W-1:0]        out_tag
);

    // Product and sum width. Intermediate results may wrap inside P bits,
    // because the final re/im are known to fit.
    localparam int P  = 2*N+3;
    localparam int XW = (OUT_W > P) ? OUT_W : P;
    localparam logic signed [P-1:0] RND =
        (SHIFT > 0) ? (P'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic en;
    logic conj_eff;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

`ifdef CMULT_CONJ_EN
    assign conj_eff = conj;
`else
    // The port is kept so the interface does not change. Its value is forced to 0.
    assign conj_eff = conj & 1'b0;
`endif

    // Stage 0 inputs. b is widened by one bit first, so that negating
    // -2^(N-1) gives an exact result.
    logic signed [N:0]   br_in, bi_in;
    logic signed [N+1:0] sa_in, sb_in;

    assign br_in = (N+1)'(b_r);
    assign bi_in = conj_eff ? -(N+1)'(b_i) : (N+1)'(b_i);
    assign sa_in = (N+2)'(a_r) + (N+2)'(a_i);
    assign sb_in = (N+2)'(br_in) + (N+2)'(bi_in);

    logic signed [N-1:0]  ar0, ai0;
    logic signed [N:0]    br0, bi0;
    logic signed [N+1:0]  sa0, sb0;
    logic signed [P-1:0]  k1, k2, k3;
    logic signed [P-1:0]  re2, im2;
    logic [3:0]              vld_pipe;
    logic [3:0][TAG_W-1:0]   tag_pipe;

    // Round half-up, shift, then clamp into OUT_W bits.
    // The returned MSB is the overflow flag.
    function automatic logic [OUT_W:0] round_sat(input logic signed [P-1:0] x);
        logic signed [P-1:0]  xs;
        logic signed [XW-1:0] xe;
        logic                 fits;
        xs   = (x + RND) >>> SHIFT;
        xe   = XW'(xs);
        fits = (&xe[XW-1:OUT_W-1]) || !(|xe[XW-1:OUT_W-1]);
        if (fits)
            round_sat = {1'b0, xe[OUT_W-1:0]};
        else
            round_sat = {1'b1, xe[XW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}}};
    endfunction

    logic [OUT_W:0] sat_r, sat_i;

    assign sat_r = round_sat(re2);
    assign sat_i = round_sat(im2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar0      <= '0;
            ai0      <= '0;
            br0      <= '0;
            bi0      <= '0;
            sa0      <= '0;
            sb0      <= '0;
            k1       <= '0;
            k2       <= '0;
            k3       <= '0;
            re2      <= '0;
            im2      <= '0;
            c_r      <= '0;
            c_i      <= '0;
            out_ovf  <= 1'b0;
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (en) begin
            // stage 0: operand capture and pre-adds
            ar0 <= a_r;
            ai0 <= a_i;
            br0 <= br_in;
            bi0 <= bi_in;
            sa0 <= sa_in;
            sb0 <= sb_in;
            // stage 1: the three products
            k1  <= P'(br0) * P'(sa0);
            k2  <= P'(ar0) * (P'(bi0) - P'(br0));
            k3  <= P'(ai0) * P'(sb0);
            // stage 2: re = ar*br - ai*bi, im = ar*bi + ai*br
            re2 <= k1 - k3;
            im2 <= k1 + k2;
            // stage 3: scaled, saturated output register
            c_r     <= sat_r[OUT_W-1:0];
            c_i     <= sat_i[OUT_W-1:0];
            out_ovf <= sat_r[OUT_W] | sat_i[OUT_W];
            // valid bits and tags move in lockstep with the data
            vld_pipe <= {vld_pipe[2:0], in_valid};
            tag_pipe <= {tag_pipe[2:0], in_tag};
        end
    end

    assign out_valid = vld_pipe[3];
    assign out_tag   = tag_pipe[3];

endmodule
